// File: rtl/csa_seq_pkg.sv
// Shared types and sizing for the sequential carry-select adder.
// Default geometry is 16 bits processed as four 4-bit slices.
package csa_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;
  localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;

  // Slice index width; a single-slice build still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_w(NSLICE);

endpackage

// File: rtl/csa_slice.sv
// Combinational W-bit carry-select slice: two ripple chains, output picked by carry-in.
// Also exposes the carry into the MSB so the sequencer can derive signed overflow.
module csa_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         msb_cin
);

  logic [W-1:0] s0, s1;
  logic [W:0]   cy0, cy1;

  always_comb begin
    cy0    = '0;
    cy1    = '0;
    s0     = '0;
    s1     = '0;
    cy0[0] = 1'b0;
    cy1[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      s0[i]     = a[i] ^ b[i] ^ cy0[i];
      cy0[i+1]  = (a[i] & b[i]) | (cy0[i] & (a[i] ^ b[i]));
      s1[i]     = a[i] ^ b[i] ^ cy1[i];
      cy1[i+1]  = (a[i] & b[i]) | (cy1[i] & (a[i] ^ b[i]));
    end
  end

  assign s       = cin ? s1 : s0;
  assign cout    = cin ? cy1[W] : cy0[W];
  assign msb_cin = cin ? cy1[W-1] : cy0[W-1];

endmodule

// File: rtl/csa_seq_ctrl.sv
// Sequential WIDTH-bit adder reusing one SLICE-bit carry-select slice, one slice per cycle.
// Optional subtract mode via macro CSA_SEQ_SUB_EN (adds port sub).
module csa_seq_ctrl
  import csa_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef CSA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int NS = WIDTH / SLICE;
  localparam int IW = idx_w(NS);
  localparam logic [IW-1:0] LAST = IW'(NS - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cy;

  logic [SLICE-1:0] sl_s;
  logic             sl_co, sl_msb;

  csa_slice #(.W(SLICE)) u_slice (
    .a       (a_q[idx*SLICE +: SLICE]),
    .b       (b_q[idx*SLICE +: SLICE]),
    .cin     (cy),
    .s       (sl_s),
    .cout    (sl_co),
    .msb_cin (sl_msb)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cy        <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
`ifdef CSA_SEQ_SUB_EN
            // Subtraction is a + ~b + 1, so the initial carry is forced high.
            b_q <= sub ? ~b : b;
            cy  <= sub | c_in;
`else
            b_q <= b;
            cy  <= c_in;
`endif
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sum[idx*SLICE +: SLICE] <= sl_s;
          cy  <= sl_co;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            c_out     <= sl_co;
            ovf       <= sl_msb ^ sl_co;
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
